// File: rtl/ahb_gpio_pkg.sv
// Shared constants, error-sequencing states and byte-lane decode for ahb_gpio_bank.
package ahb_gpio_pkg;

  localparam logic [4:0] OFF_IN      = 5'h00;
  localparam logic [4:0] OFF_OUT     = 5'h04;
  localparam logic [4:0] OFF_DIR     = 5'h08;
  localparam logic [4:0] OFF_SET     = 5'h0C;
  localparam logic [4:0] OFF_CLR     = 5'h10;
  localparam logic [4:0] OFF_RISE_EN = 5'h14;
  localparam logic [4:0] OFF_FALL_EN = 5'h18;
  localparam logic [4:0] OFF_STATUS  = 5'h1C;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} err_state_t;

  function automatic logic [3:0] byte_strobe(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] s;
    s = '0;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << addr;
      HSIZE_HALF: s = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: s = 4'b1111;
      default:    s = '0;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

endpackage

// File: rtl/ahb_gpio_bank_input_sync.sv
// Per-bank input path: synchroniser, optional debouncer (GPIO_DEBOUNCE_EN), edge detector.
module gpio_input_sync #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
`ifdef GPIO_DEBOUNCE_EN
  input  logic             tick,
`endif
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= pins;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [WIDTH-1:0] deb_q;
  logic [1:0]       cnt_q [WIDTH];

  // A pin must differ from the debounced value on 4 consecutive ticks to flip it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q <= '0;
      cnt_q <= '{default: '0};
    end else if (tick) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_q[SYNC_STAGES-1][i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == 2'd3) begin
          deb_q[i] <= sync_q[SYNC_STAGES-1][i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 2'd1;
        end
      end
    end
  end

  assign cur = deb_q;
`else
  assign cur = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= '0;
    else     prev_q <= cur;
  end

  assign rise = cur & ~prev_q;
  assign fall = ~cur & prev_q;

endmodule

// File: rtl/ahb_gpio_bank.sv
// AHB-Lite GPIO slave with NUM_BANKS banks; GPIO_DEBOUNCE_EN adds a shared debounce divisor register.
module ahb_gpio_bank
  import ahb_gpio_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  START_ADDR  = '0,
  parameter int unsigned            NUM_BANKS   = 4,
  parameter int unsigned            BANK_WIDTH  = 16,
  parameter int unsigned            SYNC_STAGES = 2
) (
  input  logic                            HCLK,
  input  logic                            HRESET,
  input  logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_in,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_out,
  output logic [NUM_BANKS*BANK_WIDTH-1:0] gpio_oe,
  output logic                            irq,
  input  logic [ADDR_WIDTH-1:0]           haddr,
  input  logic [DATA_WIDTH-1:0]           hwdata,
  output logic [DATA_WIDTH-1:0]           hrdata,
  input  logic                            hwrite,
  input  logic                            hsel,
  input  logic [1:0]                      htrans,
  input  logic [2:0]                      hsize,
  output logic                            hready,
  output logic                            hresp
);

  localparam int unsigned           NB       = NUM_BANKS;
  localparam int unsigned           BW       = BANK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WIN_SIZE = ADDR_WIDTH'(NB * 32);

  typedef logic [BW-1:0] bank_t;

  err_state_t state_q, state_d;
  bank_t out_q [NB], dir_q [NB], ren_q [NB], fen_q [NB], sts_q [NB];
  bank_t out_d [NB], dir_d [NB], ren_d [NB], fen_d [NB], sts_d [NB];
  bank_t cur [NB], rise [NB], fall [NB];

  logic [ADDR_WIDTH-1:0] rel;
  logic [2:0]  a_bank, dp_bank;
  logic [4:0]  a_off, dp_off;
  logic        a_win, a_dbn, a_err, accept, dp_wr, sts_any;
  logic [3:0]  dp_strb;
  logic [31:0] wmask, wval, rdata;
  logic        unused_bits;

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0] div_q, div_d, tick_cnt_q;
  logic        tick, dp_dbn;
`endif

  always_comb begin
    rel    = haddr - START_ADDR;
    a_bank = rel[7:5];
    a_off  = {rel[4:2], 2'b00};
    a_win  = rel < WIN_SIZE;
`ifdef GPIO_DEBOUNCE_EN
    a_dbn  = {rel[ADDR_WIDTH-1:2], 2'b00} == WIN_SIZE;
`else
    a_dbn  = 1'b0;
`endif
    a_err  = !(a_win || a_dbn) || (hsize > HSIZE_WORD)
          || (hsize == HSIZE_HALF && haddr[0])
          || (hsize == HSIZE_WORD && haddr[1:0] != 2'b00)
          || (hwrite && a_win && a_off == OFF_IN);
    accept = hsel && htrans[1] && (state_q != ST_ERR1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && a_err) state_d = ST_ERR1;
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = 1'b1;
        state_d = (accept && a_err) ? ST_ERR1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Edge events are OR-ed in after the W1C mask so a coincident edge keeps the bit set.
  always_comb begin
    wmask   = lane_mask(dp_strb);
    wval    = hwdata & wmask;
    sts_any = 1'b0;
    for (int unsigned b = 0; b < NB; b++) begin
      out_d[b] = out_q[b];
      dir_d[b] = dir_q[b];
      ren_d[b] = ren_q[b];
      fen_d[b] = fen_q[b];
      sts_d[b] = sts_q[b] | (rise[b] & ren_q[b]) | (fall[b] & fen_q[b]);
      if (dp_wr && dp_bank == 3'(b)) begin
        case (dp_off)
          OFF_OUT:     out_d[b] = (out_q[b] & ~wmask[BW-1:0]) | wval[BW-1:0];
          OFF_DIR:     dir_d[b] = (dir_q[b] & ~wmask[BW-1:0]) | wval[BW-1:0];
          OFF_SET:     out_d[b] = out_q[b] | wval[BW-1:0];
          OFF_CLR:     out_d[b] = out_q[b] & ~wval[BW-1:0];
          OFF_RISE_EN: ren_d[b] = (ren_q[b] & ~wmask[BW-1:0]) | wval[BW-1:0];
          OFF_FALL_EN: fen_d[b] = (fen_q[b] & ~wmask[BW-1:0]) | wval[BW-1:0];
          OFF_STATUS:  sts_d[b] = (sts_q[b] & ~wval[BW-1:0])
                                | (rise[b] & ren_q[b]) | (fall[b] & fen_q[b]);
          default: ;
        endcase
      end
      sts_any = sts_any | (|sts_q[b]);
    end
  end

  // Reads sample next-state values so a read overlapping a write's data phase sees the new data.
  always_comb begin
    rdata = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (a_win && a_bank == 3'(b)) begin
        case (a_off)
          OFF_IN:      rdata[BW-1:0] = cur[b];
          OFF_OUT:     rdata[BW-1:0] = out_d[b];
          OFF_DIR:     rdata[BW-1:0] = dir_d[b];
          OFF_RISE_EN: rdata[BW-1:0] = ren_d[b];
          OFF_FALL_EN: rdata[BW-1:0] = fen_d[b];
          OFF_STATUS:  rdata[BW-1:0] = sts_d[b];
          default:     rdata = '0;
        endcase
      end
    end
`ifdef GPIO_DEBOUNCE_EN
    if (a_dbn) rdata[15:0] = div_d;
`endif
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      out_q   <= '{default: '0};
      dir_q   <= '{default: '0};
      ren_q   <= '{default: '0};
      fen_q   <= '{default: '0};
      sts_q   <= '{default: '0};
      dp_wr   <= 1'b0;
      dp_bank <= '0;
      dp_off  <= '0;
      dp_strb <= '0;
      hrdata  <= '0;
      irq     <= 1'b0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ren_q   <= ren_d;
      fen_q   <= fen_d;
      sts_q   <= sts_d;
      dp_wr   <= accept && !a_err && hwrite && a_win;
      dp_bank <= a_bank;
      dp_off  <= a_off;
      dp_strb <= byte_strobe(hsize, haddr[1:0]);
      hrdata  <= (accept && !a_err && !hwrite) ? rdata : '0;
      irq     <= sts_any;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  always_comb begin
    div_d = div_q;
    if (dp_dbn) div_d = (div_q & ~wmask[15:0]) | wval[15:0];
  end

  assign tick = tick_cnt_q >= div_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      div_q      <= '0;
      tick_cnt_q <= '0;
      dp_dbn     <= 1'b0;
    end else begin
      div_q      <= div_d;
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 16'd1;
      dp_dbn     <= accept && !a_err && hwrite && a_dbn;
    end
  end
`endif

  for (genvar g = 0; g < NB; g++) begin : g_bank
    gpio_input_sync #(
      .WIDTH      (BW),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk (HCLK),
      .rst (HRESET),
`ifdef GPIO_DEBOUNCE_EN
      .tick(tick),
`endif
      .pins(gpio_in[g*BW +: BW]),
      .cur (cur[g]),
      .rise(rise[g]),
      .fall(fall[g])
    );
    assign gpio_out[g*BW +: BW] = out_q[g];
    assign gpio_oe[g*BW +: BW]  = dir_q[g];
  end

  assign unused_bits = ^{htrans[0], rel[1:0], wmask, wval};

endmodule
